ssd_scan_driver: RTL

//  Downstream display stage for the combination lock FSM. Takes the FSM's 20-bit ssd

---
 rtl/ssd_scan_if.sv | 28 ++
 rtl/ssd_scan_driver.sv | 112 +++++++++++
 2 files changed

// File: rtl/ssd_scan_if.sv
// Signal bundle between the lock FSM (master) and the 7-segment scan driver (slave).
// The master supplies the character word and blink mask; the slave drives the display pins.
interface ssd_scan_if;
    logic [19:0] ssd;
    logic [3:0]  blink_mask;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        blink_on;

    modport master (
        output ssd,
        output blink_mask,
        input  an,
        input  seg,
        input  dp,
        input  blink_on
    );

    modport slave (
        input  ssd,
        input  blink_mask,
        output an,
        output seg,
        output dp,
        output blink_on
    );
endinterface

// File: rtl/ssd_scan_driver.sv
// Time-multiplexes four 5-bit character codes onto a common-anode 7-segment display
// (active-low anodes/segments) and generates the blink phase for digits under entry.
module ssd_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    ssd_scan_if.slave  bus
);
    localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);
    localparam logic [6:0]    SEG_BLANK    = 7'b1111111;

    logic [RW-1:0] refresh_cnt, refresh_cnt_next;
    logic [BW-1:0] blink_cnt, blink_cnt_next;
    logic [1:0]    digit_idx, digit_idx_next;
    logic          blink_on, blink_on_next;
    logic [4:0]    char_code;
    logic [6:0]    glyph;
    logic [6:0]    seg_next;
    logic [3:0]    an_next;
    logic [3:0]    an;
    logic [6:0]    seg;

    // Refresh and blink timers run independently; both may wrap on the same cycle.
    always_comb begin
        refresh_cnt_next = refresh_cnt + RW'(1);
        digit_idx_next   = digit_idx;
        blink_cnt_next   = blink_cnt + BW'(1);
        blink_on_next    = blink_on;
        if (refresh_cnt == REFRESH_LAST) begin
            refresh_cnt_next = '0;
            digit_idx_next   = digit_idx + 2'd1;
        end
        if (blink_cnt == BLINK_LAST) begin
            blink_cnt_next = '0;
            blink_on_next  = ~blink_on;
        end
    end

    always_comb begin
        char_code = bus.ssd[4:0];
        case (digit_idx)
            2'd0: char_code = bus.ssd[4:0];
            2'd1: char_code = bus.ssd[9:5];
            2'd2: char_code = bus.ssd[14:10];
            2'd3: char_code = bus.ssd[19:15];
            default: char_code = bus.ssd[4:0];
        endcase
    end

    // Segment order {g,f,e,d,c,b,a}, active low; unused codes fall through to blank.
    always_comb begin
        glyph = SEG_BLANK;
        case (char_code)
            5'd0:  glyph = 7'b1000000;
            5'd1:  glyph = 7'b1111001;
            5'd2:  glyph = 7'b0100100;
            5'd3:  glyph = 7'b0110000;
            5'd4:  glyph = 7'b0011001;
            5'd5:  glyph = 7'b0010010;
            5'd6:  glyph = 7'b0000010;
            5'd7:  glyph = 7'b1111000;
            5'd8:  glyph = 7'b0000000;
            5'd9:  glyph = 7'b0010000;
            5'd10: glyph = 7'b0001000;
            5'd11: glyph = 7'b0000011;
            5'd12: glyph = 7'b1000110;
            5'd13: glyph = 7'b0100001;
            5'd14: glyph = 7'b0000110;
            5'd15: glyph = 7'b0001110;
            5'd16: glyph = 7'b1000111;
            5'd17: glyph = 7'b0100001;
            5'd18: glyph = 7'b0001100;
            5'd19: glyph = 7'b0101011;
            5'd20: glyph = 7'b0111111;
            default: glyph = SEG_BLANK;
        endcase
    end

    // The anode stays on while a blinking digit is blanked so the scan duty cycle is unchanged.
    always_comb begin
        an_next  = ~(4'b0001 << digit_idx);
        seg_next = (bus.blink_mask[digit_idx] && !blink_on) ? SEG_BLANK : glyph;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_cnt <= '0;
            digit_idx   <= 2'd0;
            blink_cnt   <= '0;
            blink_on    <= 1'b1;
            an          <= 4'b1111;
            seg         <= SEG_BLANK;
        end else begin
            refresh_cnt <= refresh_cnt_next;
            digit_idx   <= digit_idx_next;
            blink_cnt   <= blink_cnt_next;
            blink_on    <= blink_on_next;
            an          <= an_next;
            seg         <= seg_next;
        end
    end

    assign bus.an       = an;
    assign bus.seg      = seg;
    assign bus.dp       = 1'b1;
    assign bus.blink_on = blink_on;
endmodule
